// File: rtl/slave_arbiter.sv
// Per-slave arbitration stage of a 2x2 crossbar: round-robin pick between two
// masters, latch the winner's transaction, and hold the grant through the return path.
module slave_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_cmd,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_cmd,
    input  logic [DW-1:0] m1_wdata,
    input  logic          slave_ack,
    output logic          slave_req,
    output logic [AW-1:0] slave_addr,
    output logic          slave_cmd,
    output logic [DW-1:0] slave_wdata,
    output logic          granted_0,
    output logic          granted_1,
    output logic          timeout_err
);

    // One counter serves both the BUSY watchdog and the HOLD window.
    localparam int CNT_MAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [1:0]    req_vec;
    logic [1:0]    cmd_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            if (gi == 0) begin : g_m0
                assign req_vec[gi]   = m0_req;
                assign cmd_vec[gi]   = m0_cmd;
                assign addr_vec[gi]  = m0_addr;
                assign wdata_vec[gi] = m0_wdata;
            end else begin : g_m1
                assign req_vec[gi]   = m1_req;
                assign cmd_vec[gi]   = m1_cmd;
                assign addr_vec[gi]  = m1_addr;
                assign wdata_vec[gi] = m1_wdata;
            end
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          slave_req_reg, slave_req_next;
    logic [1:0]    granted_reg, granted_next;
    logic          timeout_err_reg, timeout_err_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          cmd_reg, cmd_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic          sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            owner_reg       <= 1'b0;
            last_reg        <= 1'b1;
            slave_req_reg   <= 1'b0;
            granted_reg     <= 2'b00;
            timeout_err_reg <= 1'b0;
            addr_reg        <= '0;
            cmd_reg         <= 1'b0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            owner_reg       <= owner_next;
            last_reg        <= last_next;
            slave_req_reg   <= slave_req_next;
            granted_reg     <= granted_next;
            timeout_err_reg <= timeout_err_next;
            addr_reg        <= addr_next;
            cmd_reg         <= cmd_next;
            wdata_reg       <= wdata_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        owner_next       = owner_reg;
        last_next        = last_reg;
        slave_req_next   = slave_req_reg;
        granted_next     = granted_reg;
        timeout_err_next = 1'b0;
        addr_next        = addr_reg;
        cmd_next         = cmd_reg;
        wdata_next       = wdata_reg;
        sel              = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_vec != 2'b00) begin
                    // On a tie the master that did not go last wins.
                    sel            = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
                    owner_next     = sel;
                    state_next     = ST_BUSY;
                    slave_req_next = 1'b1;
                    granted_next   = 2'b01 << sel;
                    cnt_next       = '0;
                    addr_next      = addr_vec[sel];
                    cmd_next       = cmd_vec[sel];
                    wdata_next     = wdata_vec[sel];
                end
            end

            ST_BUSY: begin
                if (slave_ack) begin
                    state_next     = ST_HOLD;
                    slave_req_next = 1'b0;
                    cnt_next       = '0;
                end else if (!req_vec[owner_reg] || cnt_reg == BUSY_LAST) begin
                    // Master withdrew or slave never answered: release without HOLD.
                    state_next       = ST_IDLE;
                    slave_req_next   = 1'b0;
                    granted_next     = 2'b00;
                    last_next        = owner_reg;
                    cnt_next         = '0;
                    timeout_err_next = req_vec[owner_reg];
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next   = ST_IDLE;
                    granted_next = 2'b00;
                    last_next    = owner_reg;
                    cnt_next     = '0;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            default: begin
                state_next     = ST_IDLE;
                slave_req_next = 1'b0;
                granted_next   = 2'b00;
                cnt_next       = '0;
            end
        endcase
    end

    assign slave_req   = slave_req_reg;
    assign slave_addr  = addr_reg;
    assign slave_cmd   = cmd_reg;
    assign slave_wdata = wdata_reg;
    assign granted_0   = granted_reg[0];
    assign granted_1   = granted_reg[1];
    assign timeout_err = timeout_err_reg;

endmodule
